// File: rtl/victim_buffer_assoc.sv
// Fully-associative victim buffer between the dcache datapath and memory.
// Holds displaced lines for re-lookup and writes dirty ones back on replace or flush.
module victim_buffer_assoc #(
    parameter int ENTRIES        = 4,
    parameter int LINE_WIDTH     = 128,
    parameter int LINE_ADDR_BITS = 28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lookup_req_i,
    input  logic [LINE_ADDR_BITS-1:0]    lookup_addr_i,
    output logic                         lookup_hit_o,
    output logic [LINE_WIDTH-1:0]        lookup_data_o,
    output logic                         lookup_dirty_o,
    input  logic                         insert_req_i,
    input  logic [LINE_ADDR_BITS-1:0]    insert_addr_i,
    input  logic [LINE_WIDTH-1:0]        insert_data_i,
    input  logic                         insert_dirty_i,
    output logic                         insert_ready_o,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [LINE_ADDR_BITS-1:0]    wb_addr_o,
    output logic [LINE_WIDTH-1:0]        wb_data_o,
    input  logic                         flush_i,
    output logic                         flush_done_o,
    output logic [$clog2(ENTRIES+1)-1:0] occupancy_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = $clog2(ENTRIES+1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FLUSH} state_e;

    state_e                                  state_q, state_d;
    logic [ENTRIES-1:0]                      valid_q, valid_d, dirty_q, dirty_d;
    logic [ENTRIES-1:0][LINE_ADDR_BITS-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][LINE_WIDTH-1:0]      data_q, data_d;
    logic [IDX_W-1:0]                        rr_q, rr_d, scan_q, scan_d;
    logic [LINE_ADDR_BITS-1:0]               wb_addr_q, wb_addr_d;
    logic [LINE_WIDTH-1:0]                   wb_data_q, wb_data_d;
    logic                                    hit_q, hit_d, hit_dirty_q, hit_dirty_d;
    logic                                    done_q, done_d;
    logic [LINE_WIDTH-1:0]                   hit_data_q, hit_data_d;
    logic [OCC_W-1:0]                        occ_q, occ_d;

    logic [ENTRIES-1:0] lk_hit, ins_match, free_vec;
    logic [IDX_W-1:0]   free_idx;
    logic               flush_wb;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            lk_hit[i]    = lookup_req_i && (state_q != S_FLUSH) && valid_q[i] && (tag_q[i] == lookup_addr_i);
            ins_match[i] = valid_q[i] && (tag_q[i] == insert_addr_i);
        end
    end

    // An entry hit this cycle is leaving for the dcache, so it is reusable now.
    assign free_vec = ~valid_q | lk_hit;

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--)
            if (free_vec[i]) free_idx = IDX_W'(i);
    end

    assign flush_wb = (state_q == S_FLUSH) && valid_q[scan_q] && dirty_q[scan_q];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q & ~lk_hit;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        rr_d        = rr_q;
        scan_d      = scan_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        done_d      = 1'b0;
        hit_d       = |lk_hit;
        hit_data_d  = '0;
        hit_dirty_d = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_hit[i]) begin
                hit_data_d  = hit_data_d | data_q[i];
                hit_dirty_d = hit_dirty_d | dirty_q[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                    scan_d  = '0;
                end else if (insert_req_i) begin
                    if (|ins_match) begin
                        for (int i = 0; i < ENTRIES; i++) begin
                            if (ins_match[i]) begin
                                valid_d[i] = 1'b1;
                                dirty_d[i] = dirty_q[i] | insert_dirty_i;
                                data_d[i]  = insert_data_i;
                            end
                        end
                    end else if (|free_vec) begin
                        valid_d[free_idx] = 1'b1;
                        dirty_d[free_idx] = insert_dirty_i;
                        tag_d[free_idx]   = insert_addr_i;
                        data_d[free_idx]  = insert_data_i;
                    end else begin
                        if (dirty_q[rr_q]) begin
                            wb_addr_d = tag_q[rr_q];
                            wb_data_d = data_q[rr_q];
                            state_d   = S_WB;
                        end
                        valid_d[rr_q] = 1'b1;
                        dirty_d[rr_q] = insert_dirty_i;
                        tag_d[rr_q]   = insert_addr_i;
                        data_d[rr_q]  = insert_data_i;
                        rr_d          = rr_q + IDX_W'(1);
                    end
                end
            end
            S_WB: begin
                if (wb_ready_i) state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (!flush_wb || wb_ready_i) begin
                    dirty_d[scan_q] = 1'b0;
                    if (scan_q == IDX_W'(ENTRIES-1)) begin
                        valid_d = '0;
                        dirty_d = '0;
                        rr_d    = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        scan_d = scan_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        occ_d = '0;
        for (int i = 0; i < ENTRIES; i++)
            occ_d = occ_d + OCC_W'(valid_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            rr_q        <= '0;
            scan_q      <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            hit_q       <= 1'b0;
            hit_data_q  <= '0;
            hit_dirty_q <= 1'b0;
            done_q      <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            rr_q        <= rr_d;
            scan_q      <= scan_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            hit_q       <= hit_d;
            hit_data_q  <= hit_data_d;
            hit_dirty_q <= hit_dirty_d;
            done_q      <= done_d;
            occ_q       <= occ_d;
        end
    end

    // Tag/data storage is qualified by valid bits and needs no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign lookup_hit_o   = hit_q;
    assign lookup_data_o  = hit_data_q;
    assign lookup_dirty_o = hit_dirty_q;
    assign insert_ready_o = (state_q == S_IDLE) && !flush_i;
    assign wb_valid_o     = (state_q == S_WB) || flush_wb;
    assign wb_addr_o      = (state_q == S_WB) ? wb_addr_q : (flush_wb ? tag_q[scan_q] : '0);
    assign wb_data_o      = (state_q == S_WB) ? wb_data_q : (flush_wb ? data_q[scan_q] : '0);
    assign flush_done_o   = done_q;
    assign occupancy_o    = occ_q;

endmodule

// File: tb/tb_victim_buffer_assoc.sv
// Directed and random stimulus for victim_buffer_assoc, checked cycle by cycle
// against a line-list model of the buffer.
module tb_victim_buffer_assoc;
    localparam int E = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         lookup_req_i;
    logic [27:0]  lookup_addr_i;
    logic         lookup_hit_o;
    logic [127:0] lookup_data_o;
    logic         lookup_dirty_o;
    logic         insert_req_i;
    logic [27:0]  insert_addr_i;
    logic [127:0] insert_data_i;
    logic         insert_dirty_i;
    logic         insert_ready_o;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [27:0]  wb_addr_o;
    logic [127:0] wb_data_o;
    logic         flush_i;
    logic         flush_done_o;
    logic [2:0]   occupancy_o;

    victim_buffer_assoc dut (
        .clk(clk), .rst(rst),
        .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
        .lookup_hit_o(lookup_hit_o), .lookup_data_o(lookup_data_o), .lookup_dirty_o(lookup_dirty_o),
        .insert_req_i(insert_req_i), .insert_addr_i(insert_addr_i), .insert_data_i(insert_data_i),
        .insert_dirty_i(insert_dirty_i), .insert_ready_o(insert_ready_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model: a list of line slots, a pending victim, and a queue of per-slot flush steps.
    typedef struct { logic v; logic d; logic [27:0] a; logic [127:0] dat; } line_t;
    typedef struct { logic wb; logic [27:0] a; logic [127:0] dat; } fitem_t;
    line_t    m_ent [E];
    line_t    m_wb;
    fitem_t   fq [$];
    int       m_rr, m_mode;  // mode: 0 idle, 1 writing victim back, 2 flushing
    logic     e_hit, e_ldirty, e_done;
    logic [127:0] e_ldata;

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < E; i++) if (m_ent[i].v) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < E; i++) m_ent[i] = '{1'b0, 1'b0, 28'h0, 128'h0};
        fq.delete();
        m_rr = 0; m_mode = 0;
        e_hit = 1'b0; e_ldirty = 1'b0; e_done = 1'b0; e_ldata = '0;
    endtask

    task automatic model_step();
        int hi = -1, mi = -1, f = -1;
        if (lookup_req_i && m_mode != 2)
            for (int i = 0; i < E; i++) if (m_ent[i].v && m_ent[i].a == lookup_addr_i) hi = i;
        for (int i = 0; i < E; i++) if (m_ent[i].v && m_ent[i].a == insert_addr_i) mi = i;
        e_hit    = (hi >= 0);
        e_ldata  = (hi >= 0) ? m_ent[hi].dat : '0;
        e_ldirty = (hi >= 0) ? m_ent[hi].d : 1'b0;
        e_done   = 1'b0;
        if (hi >= 0) m_ent[hi].v = 1'b0;
        case (m_mode)
            0: if (flush_i) begin
                m_mode = 2;
                fq.delete();
                for (int i = 0; i < E; i++)
                    fq.push_back('{m_ent[i].v && m_ent[i].d, m_ent[i].a, m_ent[i].dat});
            end else if (insert_req_i) begin
                if (mi >= 0) begin
                    m_ent[mi].v = 1'b1;
                    m_ent[mi].d = m_ent[mi].d | insert_dirty_i;
                    m_ent[mi].dat = insert_data_i;
                end else begin
                    for (int i = E-1; i >= 0; i--) if (!m_ent[i].v) f = i;
                    if (f < 0) begin
                        f = m_rr;
                        if (m_ent[f].d) begin m_wb = m_ent[f]; m_mode = 1; end
                        m_rr = (m_rr + 1) % E;
                    end
                    m_ent[f] = '{1'b1, insert_dirty_i, insert_addr_i, insert_data_i};
                end
            end
            1: if (wb_ready_i) m_mode = 0;
            default: if (!(fq[0].wb && !wb_ready_i)) begin
                void'(fq.pop_front());
                if (fq.size() == 0) begin
                    for (int i = 0; i < E; i++) begin m_ent[i].v = 1'b0; m_ent[i].d = 1'b0; end
                    m_rr = 0; e_done = 1'b1; m_mode = 0;
                end
            end
        endcase
    endtask

    // Inputs are set just after a rising edge; this checks the combinational
    // outputs, advances the model, crosses the edge and checks registered outputs.
    task automatic tick();
        logic ewv;
        logic [27:0] ea;
        logic [127:0] ed;
        #1;
        chk("insert_ready", 128'(insert_ready_o), 128'(m_mode == 0 && !flush_i));
        ewv = (m_mode == 1) || (m_mode == 2 && fq.size() > 0 && fq[0].wb);
        ea  = (m_mode == 1) ? m_wb.a : ((m_mode == 2 && fq.size() > 0) ? fq[0].a : 28'h0);
        ed  = (m_mode == 1) ? m_wb.dat : ((m_mode == 2 && fq.size() > 0) ? fq[0].dat : 128'h0);
        chk("wb_valid", 128'(wb_valid_o), 128'(ewv));
        if (ewv) begin
            chk("wb_addr", 128'(wb_addr_o), 128'(ea));
            chk("wb_data", wb_data_o, ed);
        end
        if (rst) model_reset(); else model_step();
        @(posedge clk); #1;
        chk("lookup_hit", 128'(lookup_hit_o), 128'(e_hit));
        chk("lookup_data", lookup_data_o, e_ldata);
        chk("lookup_dirty", 128'(lookup_dirty_o), 128'(e_ldirty));
        chk("flush_done", 128'(flush_done_o), 128'(e_done));
        chk("occupancy", 128'(occupancy_o), 128'(m_occ()));
    endtask

    task automatic idle_in();
        rst = 1'b0; lookup_req_i = 1'b0; insert_req_i = 1'b0; flush_i = 1'b0;
        insert_dirty_i = 1'b0; wb_ready_i = 1'b0;
    endtask

    task automatic ins(input logic [27:0] a, input logic d);
        idle_in();
        insert_req_i = 1'b1; insert_addr_i = a; insert_dirty_i = d;
        insert_data_i = {100'h0, a};
        tick();
        idle_in();
    endtask

    task automatic look(input logic [27:0] a);
        idle_in();
        lookup_req_i = 1'b1; lookup_addr_i = a;
        tick();
        idle_in();
    endtask

    task automatic do_reset();
        idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        logic [27:0] wbq [$];
        logic [27:0] held_a;
        int n;
        idle_in();
        lookup_addr_i = '0; insert_addr_i = '0; insert_data_i = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", 128'(lookup_hit_o), 128'h0);
        chk("rst_ldata", lookup_data_o, 128'h0);
        chk("rst_wb_valid", 128'(wb_valid_o), 128'h0);
        chk("rst_wb_addr", 128'(wb_addr_o), 128'h0);
        chk("rst_wb_data", wb_data_o, 128'h0);
        chk("rst_done", 128'(flush_done_o), 128'h0);
        chk("rst_occ", 128'(occupancy_o), 128'h0);
        chk("rst_ready", 128'(insert_ready_o), 128'h1);
        rst = 1'b0;

        // Insert then lookup: hit one cycle later, entry leaves the buffer.
        ins(28'h100, 1'b0);
        chk("t1_occ1", 128'(occupancy_o), 128'd1);
        look(28'h100);
        chk("t1_hit", 128'(lookup_hit_o), 128'h1);
        chk("t1_data", lookup_data_o, 128'h100);
        chk("t1_occ0", 128'(occupancy_o), 128'd0);

        // Dirty victim on replacement, held under backpressure.
        ins(28'h10, 1'b1); ins(28'h11, 1'b0); ins(28'h12, 1'b0); ins(28'h13, 1'b0);
        ins(28'h20, 1'b0);
        chk("t2_wbv", 128'(wb_valid_o), 128'h1);
        chk("t2_wba", 128'(wb_addr_o), 128'h10);
        chk("t2_ready", 128'(insert_ready_o), 128'h0);
        held_a = wb_addr_o;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold", 128'(wb_addr_o), 128'(held_a));
        end
        wb_ready_i = 1'b1; tick(); idle_in();
        chk("t2_back_idle", 128'(insert_ready_o), 128'h1);

        // Lookup hit and insert together on a full buffer.
        idle_in();
        lookup_req_i = 1'b1; lookup_addr_i = 28'h11;
        insert_req_i = 1'b1; insert_addr_i = 28'h30; insert_data_i = 128'h30;
        tick(); idle_in();
        chk("t4_hit", 128'(lookup_hit_o), 128'h1);
        chk("t4_data", lookup_data_o, 128'h11);
        chk("t4_occ", 128'(occupancy_o), 128'd4);
        chk("t4_no_wb", 128'(wb_valid_o), 128'h0);
        look(28'h30);
        chk("t4_new", 128'(lookup_hit_o), 128'h1);

        // Clean lines replaced round-robin, no writebacks.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ins(28'h40 + 28'(i), 1'b0);
            chk("t3_no_wb", 128'(wb_valid_o), 128'h0);
        end
        chk("t3_occ", 128'(occupancy_o), 128'd4);
        look(28'h48);
        chk("t3_twice", 128'(lookup_hit_o), 128'h1);
        look(28'h44);
        chk("t3_gone", 128'(lookup_hit_o), 128'h0);

        // Flush with dirty entries 1 and 3; insert alongside flush is refused.
        do_reset();
        ins(28'h60, 1'b0); ins(28'h61, 1'b1); ins(28'h62, 1'b0); ins(28'h63, 1'b1);
        flush_i = 1'b1; insert_req_i = 1'b1; insert_addr_i = 28'h70;
        tick(); idle_in();
        n = 0;
        while (!flush_done_o && n < 20) begin
            wb_ready_i = n[0];
            #1;
            if (wb_valid_o && wb_ready_i) wbq.push_back(wb_addr_o);
            tick();
            n++;
        end
        idle_in();
        chk("t5_done", 128'(flush_done_o), 128'h1);
        chk("t5_nwb", 128'(wbq.size()), 128'd2);
        if (wbq.size() == 2) begin
            chk("t5_wb0", 128'(wbq[0]), 128'h61);
            chk("t5_wb1", 128'(wbq[1]), 128'h63);
        end
        chk("t5_occ", 128'(occupancy_o), 128'd0);
        look(28'h61);
        chk("t5_miss", 128'(lookup_hit_o), 128'h0);

        // Empty flush latency.
        flush_i = 1'b1; tick(); idle_in();
        n = 1;
        while (!flush_done_o && n < 20) begin tick(); n++; end
        chk("t5_empty_lat", 128'(n), 128'(E + 1));

        // Reset during a writeback stall.
        for (int i = 0; i < 5; i++) ins(28'h80 + 28'(i), 1'b1);
        tick(); tick();
        rst = 1'b1; tick(); idle_in();
        chk("t6_wbv", 128'(wb_valid_o), 128'h0);
        chk("t6_occ", 128'(occupancy_o), 128'd0);
        chk("t6_ready", 128'(insert_ready_o), 128'h1);

        // Random traffic over a small address pool.
        for (int c = 0; c < 800; c++) begin
            rst            = ($urandom_range(0, 249) == 0);
            lookup_req_i   = $urandom_range(0, 1) == 1;
            lookup_addr_i  = 28'($urandom_range(0, 7));
            insert_req_i   = $urandom_range(0, 1) == 1;
            insert_addr_i  = 28'($urandom_range(0, 7));
            insert_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
            insert_dirty_i = $urandom_range(0, 1) == 1;
            flush_i        = ($urandom_range(0, 39) == 0);
            wb_ready_i     = $urandom_range(0, 2) != 0;
            tick();
        end
        idle_in();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
